// File: rtl/eq_pkg.sv
// eq_pkg: shared I2S receiver widths, FSM state encoding and sample type.
package eq_pkg;
  localparam int DATA_W = 24;
  localparam int SLOT_W = 32;
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_t;
  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/i2s_slave_rx_sync_edge.sv
// i2s_sync_edge: two-flop synchroniser plus an edge flop for rising-edge detect.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], async_in};
  always_ff @(posedge clk or posedge rst)
    if (rst) sh_q <= '0;
    else sh_q <= sh_d;
  assign sync = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: oversampled I2S receiver producing signed left/right samples
// with a per-frame valid strobe and a misalignment strobe.
module i2s_slave_rx #(
  parameter int DATA_W = eq_pkg::DATA_W,
  parameter int SLOT_W = eq_pkg::SLOT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     I2S_sclk,
  input  logic                     I2S_ws,
  input  logic                     I2S_data,
  output logic signed [DATA_W-1:0] lft_chnnl,
  output logic signed [DATA_W-1:0] rght_chnnl,
  output logic                     vld,
  output logic                     sync_err
);
  import eq_pkg::*;
  localparam int CW = $clog2(SLOT_W);
  localparam logic [CW-1:0] CMAX = CW'(SLOT_W - 1);
  localparam logic [CW-1:0] CDAT = CW'(DATA_W);
  logic sclk_rise, sclk_s_unused, ws_s, ws_rise_unused, data_s, data_rise_unused;
  logic toggle, sat, adv, done;
  logic ws_prev_q, ws_prev_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [DATA_W-1:0] shreg_q, shreg_d, word;
  logic signed [DATA_W-1:0] lhold_q, lft_q, rght_q;
  logic vld_q, err_q;
  i2s_state_t state_q;
  // ws and data go through identical stages so they line up with sclk_rise
  i2s_sync_edge u_sclk (.clk(clk), .rst(rst), .async_in(I2S_sclk), .sync(sclk_s_unused), .rise(sclk_rise));
  i2s_sync_edge u_ws   (.clk(clk), .rst(rst), .async_in(I2S_ws),   .sync(ws_s),          .rise(ws_rise_unused));
  i2s_sync_edge u_data (.clk(clk), .rst(rst), .async_in(I2S_data), .sync(data_s),        .rise(data_rise_unused));
  always_comb begin
    toggle = ws_s != ws_prev_q;
    sat = cnt_q == CMAX;
    adv = toggle && sat;
    cnt_n = toggle ? '0 : (sat ? cnt_q : cnt_q + 1'b1);
    done = cnt_n == CDAT;
    word = {shreg_q[DATA_W-2:0], data_s};
    ws_prev_d = sclk_rise ? ws_s : ws_prev_q;
    cnt_d = sclk_rise ? cnt_n : cnt_q;
    shreg_d = (sclk_rise && cnt_n != '0 && cnt_n <= CDAT) ? word : shreg_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ws_prev_q <= 1'b0;
      cnt_q <= '0;
      shreg_q <= '0;
    end else begin
      ws_prev_q <= ws_prev_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
    end
  // a channel switch is only legal once the previous slot ran its full length
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SYNC;
      lhold_q <= '0;
      lft_q <= '0;
      rght_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (sclk_rise) begin
        if (state_q == SYNC) begin
          if (toggle && !ws_s) state_q <= LEFT;
        end else if (toggle || sat) begin
          state_q <= adv ? (state_q == LEFT ? RIGHT : LEFT) : SYNC;
          err_q <= !adv;
        end else if (done) begin
          if (state_q == LEFT) lhold_q <= word;
          else begin
            lft_q <= lhold_q;
            rght_q <= word;
            vld_q <= 1'b1;
          end
        end
      end
    end
  assign lft_chnnl = lft_q;
  assign rght_chnnl = rght_q;
  assign vld = vld_q;
  assign sync_err = err_q;
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: drives I2S frames bit by bit and checks captured samples,
// strobes and error pulses against frame-level expectations.
module tb_i2s_slave_rx;
  logic clk = 1'b0, rst = 1'b1, I2S_sclk = 1'b0, I2S_ws = 1'b0, I2S_data = 1'b0;
  logic signed [23:0] lft_chnnl, rght_chnnl;
  logic vld, sync_err;
  int checks = 0, fails = 0;
  int cyc = 0, err_cnt = 0, both_cnt = 0;
  int rise_t = 0, lsb_t = 0;
  logic [23:0] got_l[$], got_r[$];
  int got_t[$];

  i2s_slave_rx dut (
    .clk(clk), .rst(rst), .I2S_sclk(I2S_sclk), .I2S_ws(I2S_ws), .I2S_data(I2S_data),
    .lft_chnnl(lft_chnnl), .rght_chnnl(rght_chnnl), .vld(vld), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld) begin
      got_l.push_back(lft_chnnl);
      got_r.push_back(rght_chnnl);
      got_t.push_back(cyc);
    end
    if (sync_err) err_cnt <= err_cnt + 1;
    if (vld && sync_err) both_cnt <= both_cnt + 1;
  end

  // one sclk period: ws/data change with sclk low, sclk rises half a period later
  task automatic bit_out(input logic w, input logic d);
    I2S_ws = w;
    I2S_data = d;
    repeat (16) @(posedge clk);
    #1 I2S_sclk = 1'b1;
    rise_t = cyc;
    repeat (16) @(posedge clk);
    #1 I2S_sclk = 1'b0;
  endtask

  // slot position 0 carries junk, 1..24 the sample MSB first, the rest junk
  task automatic send_half(input logic w, input logic [23:0] s, input int nbits);
    for (int p = 0; p < nbits; p++) begin
      bit_out(w, (p >= 1 && p <= 24) ? s[24-p] : 1'($urandom_range(0, 1)));
      if (w && p == 24) lsb_t = rise_t;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_half(1'b0, l, 32);
    send_half(1'b1, r, 32);
  endtask

  task automatic do_reset();
    I2S_sclk = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (lft_chnnl !== 24'h0) begin fails++; $display("FAIL reset_lft got %h want 000000", lft_chnnl); end
    checks++; if (rght_chnnl !== 24'h0) begin fails++; $display("FAIL reset_rght got %h want 000000", rght_chnnl); end
    checks++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", vld); end
    checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int n0, e0;
    do_reset();
    n0 = got_l.size();
    e0 = err_cnt;
    send_half(1'b1, 24'($urandom), 32);
    send_frame(24'h123456, 24'hABCDEF);
    checks++; if (got_l.size() - n0 != 1) begin fails++; $display("FAIL basic_vld_count got %0d want 1", got_l.size() - n0); end
    checks++; if (lft_chnnl !== 24'h123456) begin fails++; $display("FAIL basic_lft got %h want 123456", lft_chnnl); end
    checks++; if (rght_chnnl !== 24'hABCDEF) begin fails++; $display("FAIL basic_rght got %h want abcdef", rght_chnnl); end
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL basic_sync_err got %0d want 0", err_cnt - e0); end
    if (got_t.size() > 0) begin
      checks++;
      if (got_t[$] - lsb_t < 3 || got_t[$] - lsb_t > 4) begin
        fails++; $display("FAIL vld_latency got %0d want 3..4", got_t[$] - lsb_t);
      end
    end
  endtask

  task automatic test_midstream();
    int n0, e0;
    do_reset();
    n0 = got_l.size();
    e0 = err_cnt;
    send_half(1'b1, 24'($urandom), 12);
    send_frame(24'h000001, 24'h7FFFFF);
    checks++; if (got_l.size() - n0 != 1) begin fails++; $display("FAIL mid_vld_count got %0d want 1", got_l.size() - n0); end
    if (got_l.size() > n0) begin
      checks++; if (got_l[n0] !== 24'h000001) begin fails++; $display("FAIL mid_lft got %h want 000001", got_l[n0]); end
      checks++; if (got_r[n0] !== 24'h7FFFFF) begin fails++; $display("FAIL mid_rght got %h want 7fffff", got_r[n0]); end
    end
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL mid_sync_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [23:0] ev;
    do_reset();
    n0 = got_l.size();
    send_half(1'b1, 24'($urandom), 32);
    for (int n = 0; n < 4; n++) begin
      ev = 24'(n);
      send_frame(ev, ~ev);
    end
    checks++; if (got_l.size() - n0 != 4) begin fails++; $display("FAIL b2b_vld_count got %0d want 4", got_l.size() - n0); end
    for (int i = 0; i < 4; i++) if (n0 + i < got_l.size()) begin
      ev = 24'(i);
      checks++; if (got_l[n0+i] !== ev) begin fails++; $display("FAIL b2b_lft[%0d] got %h want %h", i, got_l[n0+i], ev); end
      checks++; if (got_r[n0+i] !== ~ev) begin fails++; $display("FAIL b2b_rght[%0d] got %h want %h", i, got_r[n0+i], ~ev); end
      if (i > 0) begin
        checks++;
        if (got_t[n0+i] - got_t[n0+i-1] != 2048) begin
          fails++; $display("FAIL b2b_spacing[%0d] got %0d want 2048", i, got_t[n0+i] - got_t[n0+i-1]);
        end
      end
    end
  endtask

  task automatic test_sign_and_random();
    int n0;
    logic [23:0] el[$], er[$];
    logic [23:0] r;
    n0 = got_l.size();
    r = 24'($urandom);
    send_frame(24'h800000, r);
    checks++; if (lft_chnnl !== 24'h800000 || !(lft_chnnl < 0)) begin fails++; $display("FAIL sign_lft got %h want 800000 negative", lft_chnnl); end
    checks++; if (rght_chnnl !== r) begin fails++; $display("FAIL sign_rght got %h want %h", rght_chnnl, r); end
    n0 = got_l.size();
    for (int i = 0; i < 3; i++) begin
      el.push_back(24'($urandom));
      er.push_back(24'($urandom));
      send_frame(el[i], er[i]);
    end
    checks++; if (got_l.size() - n0 != 3) begin fails++; $display("FAIL rand_vld_count got %0d want 3", got_l.size() - n0); end
    for (int i = 0; i < 3; i++) if (n0 + i < got_l.size()) begin
      checks++;
      if (got_l[n0+i] !== el[i] || got_r[n0+i] !== er[i]) begin
        fails++; $display("FAIL rand_frame[%0d] got %h/%h want %h/%h", i, got_l[n0+i], got_r[n0+i], el[i], er[i]);
      end
    end
  endtask

  task automatic test_early_toggle();
    int n0, e0;
    logic [23:0] a, b;
    do_reset();
    send_half(1'b1, 24'($urandom), 32);
    n0 = got_l.size();
    e0 = err_cnt;
    send_half(1'b0, 24'($urandom), 21);
    send_half(1'b1, 24'($urandom), 32);
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL early_sync_err got %0d want 1", err_cnt - e0); end
    checks++; if (got_l.size() != n0) begin fails++; $display("FAIL early_no_vld got %0d want 0", got_l.size() - n0); end
    a = 24'($urandom);
    b = 24'($urandom);
    send_frame(a, b);
    checks++; if (got_l.size() - n0 != 1) begin fails++; $display("FAIL early_resync_count got %0d want 1", got_l.size() - n0); end
    checks++; if (lft_chnnl !== a || rght_chnnl !== b) begin fails++; $display("FAIL early_resync got %h/%h want %h/%h", lft_chnnl, rght_chnnl, a, b); end
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL early_err_total got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_missing_toggle();
    int n0, e0;
    logic [23:0] a, b;
    do_reset();
    send_half(1'b1, 24'($urandom), 32);
    a = 24'($urandom);
    b = 24'($urandom);
    send_frame(a, b);
    n0 = got_l.size();
    e0 = err_cnt;
    send_half(1'b0, 24'($urandom), 32);
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL miss_err_early got %0d want 0 after 32 rises", err_cnt - e0); end
    bit_out(1'b0, 1'($urandom_range(0, 1)));
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL miss_err_rise33 got %0d want 1", err_cnt - e0); end
    send_half(1'b0, 24'($urandom), 7);
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL miss_err_total got %0d want 1", err_cnt - e0); end
    checks++; if (got_l.size() != n0) begin fails++; $display("FAIL miss_no_vld got %0d want 0", got_l.size() - n0); end
    checks++; if (lft_chnnl !== a || rght_chnnl !== b) begin fails++; $display("FAIL miss_hold got %h/%h want %h/%h", lft_chnnl, rght_chnnl, a, b); end
  endtask

  task automatic test_reset_mid();
    int n0, e0;
    logic [23:0] d, e;
    do_reset();
    send_half(1'b1, 24'($urandom), 32);
    send_frame(24'($urandom) | 24'h1, 24'($urandom) | 24'h1);
    send_half(1'b0, 24'($urandom), 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (lft_chnnl !== 24'h0 || rght_chnnl !== 24'h0) begin fails++; $display("FAIL rstmid_async got %h/%h want 000000/000000", lft_chnnl, rght_chnnl); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n0 = got_l.size();
    e0 = err_cnt;
    send_half(1'b0, 24'($urandom), 22);
    send_half(1'b1, 24'($urandom), 32);
    checks++; if (got_l.size() != n0) begin fails++; $display("FAIL rstmid_no_vld got %0d want 0", got_l.size() - n0); end
    d = 24'($urandom);
    e = 24'($urandom);
    send_frame(d, e);
    checks++; if (got_l.size() - n0 != 1) begin fails++; $display("FAIL rstmid_vld_count got %0d want 1", got_l.size() - n0); end
    checks++; if (lft_chnnl !== d || rght_chnnl !== e) begin fails++; $display("FAIL rstmid_frame got %h/%h want %h/%h", lft_chnnl, rght_chnnl, d, e); end
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL rstmid_sync_err got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midstream();
    test_back_to_back();
    test_sign_and_random();
    test_early_toggle();
    test_missing_toggle();
    test_reset_mid();
    checks++; if (both_cnt != 0) begin fails++; $display("FAIL vld_with_sync_err got %0d want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
